ifu_fetch: RTL and testbench

- Instruction-fetch sequencer sitting directly downstream of the 32-bit PC register in the IFU.
- Takes the current PC, issues a single-beat read on an AXI-lite-style instruction bus, and returns the fetched word to the decoder over a valid/ready handshake.
- Produces a one-cycle acknowledge that tells next-PC logic the instruction has been consumed and the PC may advance.
- Supports redirect (flush) at any point of an in-flight fetch.

---
 rtl/ifu_fetch.sv | 145 ++++++++++++++
 tb/tb_ifu_fetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch sequencer between the PC register and the decoder.
//
// Each fetch takes the current PC, issues one read on an AXI-lite-style
// instruction bus, and presents the returned word to the decoder over a
// valid/ready handshake. pc_ack_o pulses on the cycle the decoder accepts the
// word, which lets next-PC logic advance the PC. flush_i abandons the fetch at
// any point.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   pc_i, pc_valid_i            current PC and its valid flag
//   pc_ack_o                    instruction consumed; PC may advance this edge
//   flush_i                     redirect, abandon the current fetch
//   araddr_o/arvalid_o/arready_i        read-address channel
//   rdata_i/rresp_i/rvalid_i/rready_o   read-data channel
//   inst_o, inst_pc_o, inst_fault_o     fetched word, its PC and access fault
//   inst_valid_o, inst_ready_i          decoder handshake
module ifu_fetch #(
    parameter int unsigned                CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0]       NOP_INST  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [CPU_WIDTH-1:0] pc_i,
    input  logic                 pc_valid_i,
    output logic                 pc_ack_o,
    input  logic                 flush_i,
    output logic [CPU_WIDTH-1:0] araddr_o,
    output logic                 arvalid_o,
    input  logic                 arready_i,
    input  logic [CPU_WIDTH-1:0] rdata_i,
    input  logic [1:0]           rresp_i,
    input  logic                 rvalid_i,
    output logic                 rready_o,
    output logic [CPU_WIDTH-1:0] inst_o,
    output logic [CPU_WIDTH-1:0] inst_pc_o,
    output logic                 inst_fault_o,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i
);

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StOut
    } state_t;

    state_t               r_state;
    logic [CPU_WIDTH-1:0] r_req_pc;
    logic [CPU_WIDTH-1:0] r_araddr;
    logic                 r_arvalid;
    logic                 r_rready;
    logic [CPU_WIDTH-1:0] r_inst;
    logic [CPU_WIDTH-1:0] r_inst_pc;
    logic                 r_inst_fault;
    logic                 r_inst_valid;
    // A flush arrived while a read was still owed by the bus; its data must be
    // drained and thrown away rather than handed to the decoder.
    logic                 r_discard;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_req_pc     <= '0;
            r_araddr     <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= 1'b0;
            r_inst_valid <= 1'b0;
            r_discard    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (pc_valid_i && !flush_i) begin
                        r_req_pc <= pc_i;
                        if (pc_i[1:0] == 2'b00) begin
                            r_araddr  <= pc_i;
                            r_arvalid <= 1'b1;
                            r_state   <= StAr;
                        end else begin
                            // Misaligned PC: report a fault without touching the bus.
                            r_inst       <= NOP_INST;
                            r_inst_pc    <= pc_i;
                            r_inst_fault <= 1'b1;
                            r_inst_valid <= 1'b1;
                            r_state      <= StOut;
                        end
                    end
                end
                StAr: begin
                    // arvalid may not be withdrawn once raised, so a flush here
                    // only marks the eventual read data for discard.
                    if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= StR;
                    end
                end
                StR: begin
                    if (rvalid_i) begin
                        r_rready <= 1'b0;
                        if (r_discard || flush_i) begin
                            r_discard <= 1'b0;
                            r_state   <= StIdle;
                        end else begin
                            r_inst       <= rdata_i;
                            r_inst_pc    <= r_req_pc;
                            r_inst_fault <= (rresp_i != 2'b00);
                            r_inst_valid <= 1'b1;
                            r_state      <= StOut;
                        end
                    end else if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                StOut: begin
                    // Flush and accept both leave OUT; only accept produces an ack.
                    if (flush_i || inst_ready_i) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign pc_ack_o     = r_inst_valid & inst_ready_i & ~flush_i;
    assign araddr_o     = r_araddr;
    assign arvalid_o    = r_arvalid;
    assign rready_o     = r_rready;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_fault_o = r_inst_fault;
    assign inst_valid_o = r_inst_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: bench-side bus slave and decoder with tunable
// latencies, a scoreboard of expected instructions, and a monitor that
// compares on every pc_ack_o and checks the channel hold rules.
module tb_ifu_fetch;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clk;
    logic        rstn;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ack_o;
    logic        flush_i;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    ifu_fetch #(
        .CPU_WIDTH (32),
        .NOP_INST  (Nop)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ack_o     (pc_ack_o),
        .flush_i      (flush_i),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_fault_o (inst_fault_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Instruction memory and response map seen by the bench's bus slave.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h80000000) return 32'h00100093;
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        if (a[7:2] == 6'd5) return 2'b10;
        if (a[7:2] == 6'd9) return 2'b11;
        return 2'b00;
    endfunction

    // What the decoder must eventually receive for a fetch of pc.
    function automatic exp_t expect_of(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.inst  = Nop;
            e.fault = 1'b1;
        end else begin
            e.inst  = mem_word(pc);
            e.fault = (mem_resp(pc) != 2'b00);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Latency knobs: a value >= 0 fixes the wait, -1 randomizes it per request.
    int ar_fix  = 0;
    int r_fix   = 0;
    int rdy_fix = 0;

    // Bus slave.
    logic        s_have = 1'b0;
    logic [31:0] s_addr = '0;
    int          ar_cnt = 0, r_cnt = 0, ar_rnd = 0, r_rnd = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            s_have = 1'b0;
            ar_cnt = 0;
            r_cnt  = 0;
        end else if (arvalid_o && arready_i) begin
            s_have = 1'b1;
            s_addr = araddr_o;
            ar_cnt = 0;
            r_cnt  = 0;
            r_rnd  = $urandom_range(0, 3);
        end else if (rvalid_i && rready_o) begin
            s_have = 1'b0;
            ar_rnd = $urandom_range(0, 3);
        end else if (arvalid_o) begin
            ar_cnt++;
        end else if (s_have) begin
            r_cnt++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        arready_i = arvalid_o && !s_have && (ar_cnt >= ((ar_fix >= 0) ? ar_fix : ar_rnd));
        rvalid_i  = s_have && (r_cnt >= ((r_fix >= 0) ? r_fix : r_rnd));
        rdata_i   = mem_word(s_addr);
        rresp_i   = mem_resp(s_addr);
    end

    // Decoder: accepts after a number of cycles of inst_valid_o.
    int v_cnt = 0, rdy_rnd = 0;

    always @(negedge clk) begin
        if (!rstn || !inst_valid_o || pc_ack_o) begin
            v_cnt   = 0;
            rdy_rnd = $urandom_range(0, 3);
        end else begin
            v_cnt++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        inst_ready_i = inst_valid_o && (v_cnt >= ((rdy_fix >= 0) ? rdy_fix : rdy_rnd));
    end

    // Monitor: scoreboard compare on accept, plus channel hold rules.
    logic        p_arv = 1'b0;
    logic [31:0] p_addr = '0;
    logic        p_iv = 1'b0;
    exp_t        p_out;
    exp_t        got;

    always @(negedge clk) begin
        if (!rstn) begin
            p_arv = 1'b0;
            p_iv  = 1'b0;
        end else begin
            chk("ar_r_overlap", {95'd0, arvalid_o & rready_o}, 96'd0);
            if (p_arv) chk("ar_hold", {63'd0, arvalid_o, araddr_o}, {63'd0, 1'b1, p_addr});
            got = '{inst: inst_o, pc: inst_pc_o, fault: inst_fault_o};
            if (p_iv) chk("out_hold", {30'd0, inst_valid_o, got}, {30'd0, 1'b1, p_out});
            if (pc_ack_o) begin
                if (q.size() == 0) chk("unexpected_ack", 96'd1, 96'd0);
                else chk("inst", {31'd0, got}, {31'd0, q.pop_front()});
            end
            p_arv  = arvalid_o && !arready_i;
            p_addr = araddr_o;
            p_iv   = inst_valid_o && !inst_ready_i && !flush_i;
            p_out  = got;
        end
    end

    // Per-fetch observations, cycle 0 being the cycle pc_valid_i is raised.
    int n, t_ar, t_r, t_rv, t_iv, ar_hs;

    // Present pc until it is accepted; optionally redirect to new_pc at cycle
    // flush_at. Called and returns at posedge+1.
    task automatic run_fetch(input logic [31:0] pc, input int flush_at,
                             input logic [31:0] new_pc);
        bit done = 0;
        n = 0; t_ar = -1; t_r = -1; t_rv = -1; t_iv = -1; ar_hs = 0;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        q.push_back(expect_of(pc));
        while (!done) begin
            @(negedge clk);
            if (arvalid_o && t_ar < 0) t_ar = n;
            if (rready_o && t_r < 0) t_r = n;
            if (rvalid_i && rready_o && t_rv < 0) t_rv = n;
            if (inst_valid_o && t_iv < 0) t_iv = n;
            if (arvalid_o && arready_i) ar_hs++;
            if (pc_ack_o) begin
                done = 1;
            end else if (n >= 200) begin
                chk("fetch_timeout", 96'd1, 96'd0);
                q.delete();
                done = 1;
            end
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            if (!done) begin
                n++;
                if (n == flush_at) begin
                    flush_i = 1'b1;
                    pc_i    = new_pc;
                    void'(q.pop_back());
                    q.push_back(expect_of(new_pc));
                end
            end
        end
        pc_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
        return p;
    endfunction

    task automatic set_lat(input int a, input int r, input int d);
        ar_fix = a; r_fix = r; rdy_fix = d;
    endtask

    initial begin
        rstn = 1'b0; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0; inst_ready_i = 1'b0;
        #7;
        chk("reset_state",
            {pc_ack_o, arvalid_o, rready_o, inst_valid_o, inst_fault_o, inst_o, inst_pc_o, araddr_o},
            96'd0);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Zero-wait fetch.
        set_lat(0, 0, 0);
        run_fetch(32'h80000000, -1, '0);
        chk("zw_arvalid_cycle", 96'(t_ar), 96'd1);
        chk("zw_rready_cycle", 96'(t_r), 96'd2);
        chk("zw_valid_ack_cycle", {32'(t_iv), 32'(n)}, {32'd3, 32'd3});
        @(negedge clk);
        chk("zw_ack_single", {94'd0, pc_ack_o, inst_valid_o}, 96'd0);
        @(posedge clk); #1;

        // Bus backpressure.
        set_lat(3, 2, 0);
        run_fetch(32'h80000040, -1, '0);
        chk("bp_ar_handshakes", 96'(ar_hs), 96'd1);
        chk("bp_rvalid_cycle", 96'(t_rv), 96'd7);
        chk("bp_valid_after_rvalid", 96'(t_iv), 96'(t_rv + 1));

        // Decoder stall.
        set_lat(0, 0, 5);
        run_fetch(32'h80000080, -1, '0);
        chk("stall_cycles", {32'(t_iv), 32'(n)}, {32'd3, 32'd8});

        // Flush one cycle before rvalid, redirect to 0x80000100.
        set_lat(0, 2, 0);
        run_fetch(32'h80000000, 3, 32'h80000100);
        chk("flush_r_valid_cycle", 96'(t_iv), 96'd10);
        chk("flush_r_ar_handshakes", 96'(ar_hs), 96'd2);

        // Faults.
        set_lat(0, 0, 0);
        run_fetch(32'h80000002, -1, '0);
        chk("misaligned_no_ar", {32'(t_ar), 32'(n)}, {-32'sd1, 32'd1});
        run_fetch(32'h80000014, -1, '0);
        chk("rresp_fault_cycle", 96'(n), 96'd3);

        // Asynchronous reset in the middle of R.
        set_lat(0, 3, 0);
        pc_i = 32'h80000000; pc_valid_i = 1'b1;
        @(posedge clk); @(posedge clk);
        #3;
        chk("pre_reset_in_r", {94'd0, arvalid_o, rready_o}, 96'd1);
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {93'd0, arvalid_o, rready_o, inst_valid_o}, 96'd0);
        pc_valid_i = 1'b0;
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        set_lat(0, 0, 0);
        run_fetch(32'h80000000, -1, '0);
        chk("post_reset_fetch", 96'(n), 96'd3);

        // Randomized traffic with random latencies and redirects.
        set_lat(-1, -1, -1);
        for (int i = 0; i < 300; i++) begin
            int fa;
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : -1;
            run_fetch(rand_pc(), fa, rand_pc());
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 96'(q.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
